// File: rtl/bus_arbiter_if.sv
// Bus arbiter interface: requests, destination handshake and transfer status.
// The arbiter connects through the slave modport. The requesters and destinations
// connect through the master modport.
interface bus_arbiter_if #(
    parameter int NUM_PROC = 4
);
    localparam int IW = $clog2(NUM_PROC);

    logic [NUM_PROC-1:0]           req;
    logic [NUM_PROC-1:0][IW-1:0]   req_dest;
    logic [NUM_PROC-1:0][47:0]     req_addr;
    logic [NUM_PROC-1:0]           dest_ready;
    logic [NUM_PROC-1:0]           grant;
    logic                          bus_busy;
    logic [IW-1:0]                 xfer_src;
    logic [IW-1:0]                 xfer_dest;
    logic [NUM_PROC-1:0]           deliver_valid;
    logic [47:0]                   deliver_addr;
    logic                          err_bad_dest;

    modport master (
        output req, req_dest, req_addr, dest_ready,
        input  grant, bus_busy, xfer_src, xfer_dest,
               deliver_valid, deliver_addr, err_bad_dest
    );

    modport slave (
        input  req, req_dest, req_addr, dest_ready,
        output grant, bus_busy, xfer_src, xfer_dest,
               deliver_valid, deliver_addr, err_bad_dest
    );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter.
// The arbiter grants one requester at a time and keeps the bus for TRANSFER_TIME
// cycles. It then presents the latched address to the chosen destination until
// that destination signals ready. A destination index outside the valid range
// aborts the transfer with a one-cycle error pulse.
module bus_arbiter #(
    parameter int NUM_PROC      = 4,
    parameter int TRANSFER_TIME = 10
) (
    input  logic          clk,
    input  logic          rst_l,
    bus_arbiter_if.slave  bus
);
    localparam int IW  = $clog2(NUM_PROC);
    localparam int IWP = IW + 1;
    localparam int CW  = $clog2(TRANSFER_TIME + 1);

    localparam logic [CW-1:0]  CNT_LOAD = CW'(TRANSFER_TIME - 1);
    localparam logic [IWP-1:0] NP_EXT   = IWP'(NUM_PROC);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        XFER    = 2'd1,
        DELIVER = 2'd2
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [CW-1:0]        cnt_q;
    logic [IW-1:0]        rr_ptr_q;
    logic [IW-1:0]        src_q;
    logic [IW-1:0]        dest_q;
    logic [47:0]          addr_q;
    logic [NUM_PROC-1:0]  grant_q;
    logic                 err_q;

    logic [IW-1:0]        winner;
    logic                 found;
    logic                 req_any;
    logic                 dest_bad;
    logic                 dest_rdy;

    // Index offset from a base, wrapping at NUM_PROC. The base is always in range.
    function automatic logic [IW-1:0] idx_add(input logic [IW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_PROC) s = s - NUM_PROC;
        return IW'(s);
    endfunction

    // Pointer that follows the winner, wrapping from the last requester to 0.
    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] idx);
        if (idx == IW'(NUM_PROC - 1)) return '0;
        return idx + IW'(1);
    endfunction

    // One-hot vector with bit idx set.
    function automatic logic [NUM_PROC-1:0] onehot(input logic [IW-1:0] idx);
        logic [NUM_PROC-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    assign req_any  = |bus.req;
    assign dest_bad = ({1'b0, dest_q} >= NP_EXT);

    // Ready of the latched destination. It is forced low for an out-of-range index.
    always_comb begin
        dest_rdy = 1'b0;
        if (!dest_bad) dest_rdy = bus.dest_ready[dest_q];
    end

    // Pick the first active request at or above rr_ptr, wrapping around.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int i = 0; i < NUM_PROC; i++) begin
            if (!found && bus.req[idx_add(rr_ptr_q, i)]) begin
                found  = 1'b1;
                winner = idx_add(rr_ptr_q, i);
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic. Requests are looked at only while the bus is idle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_any) state_d = XFER;
            XFER:    if (cnt_q == '0) state_d = dest_bad ? IDLE : DELIVER;
            DELIVER: if (dest_rdy) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Control registers: grant and error pulses, countdown, round-robin pointer, latched route.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            cnt_q    <= '0;
            rr_ptr_q <= '0;
            src_q    <= '0;
            dest_q   <= '0;
            grant_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            grant_q <= '0;
            err_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_any) begin
                        grant_q  <= onehot(winner);
                        src_q    <= winner;
                        dest_q   <= bus.req_dest[winner];
                        cnt_q    <= CNT_LOAD;
                        rr_ptr_q <= wrap_inc(winner);
                    end
                end
                XFER: begin
                    if (cnt_q != '0) cnt_q <= cnt_q - CW'(1);
                    else if (dest_bad) err_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Address latch. It has no reset because deliver_addr is gated by the state.
    always_ff @(posedge clk) begin
        if (state_q == IDLE && req_any) addr_q <= bus.req_addr[winner];
    end

    // Output decode. Delivery strobe and address are visible only in DELIVER.
    always_comb begin
        bus.grant         = grant_q;
        bus.err_bad_dest  = err_q;
        bus.xfer_src      = src_q;
        bus.xfer_dest     = dest_q;
        bus.bus_busy      = (state_q != IDLE);
        bus.deliver_valid = '0;
        bus.deliver_addr  = '0;
        if (state_q == DELIVER) begin
            bus.deliver_valid = onehot(dest_q);
            bus.deliver_addr  = addr_q;
        end
    end
endmodule

// File: tb/tb_bus_arbiter.sv
// Testbench for bus_arbiter with two instances. Instance A uses NUM_PROC=4 and
// TRANSFER_TIME=10. Instance B uses NUM_PROC=3 and TRANSFER_TIME=1, so it can
// also see out-of-range destinations. A transaction-level model predicts the
// outputs of both instances.
module tb_bus_arbiter;
    logic clk   = 1'b0;
    logic rst_l = 1'b0;

    always #5 clk = ~clk;

    bus_arbiter_if #(.NUM_PROC(4)) ifa ();
    bus_arbiter_if #(.NUM_PROC(3)) ifb ();

    bus_arbiter #(.NUM_PROC(4), .TRANSFER_TIME(10)) u_dut_a (.clk(clk), .rst_l(rst_l), .bus(ifa));
    bus_arbiter #(.NUM_PROC(3), .TRANSFER_TIME(1))  u_dut_b (.clk(clk), .rst_l(rst_l), .bus(ifb));

    // Stimulus arrays. Index 0 is instance A and index 1 is instance B.
    logic [3:0]  s_req  [2];
    logic [1:0]  s_dest [2][4];
    logic [47:0] s_addr [2][4];
    logic [3:0]  s_rdy  [2];

    // Drive the interfaces from the stimulus arrays.
    always_comb begin
        ifa.req        = s_req[0];
        ifa.dest_ready = s_rdy[0];
        for (int i = 0; i < 4; i++) begin
            ifa.req_dest[i] = s_dest[0][i];
            ifa.req_addr[i] = s_addr[0][i];
        end
        ifb.req        = s_req[1][2:0];
        ifb.dest_ready = s_rdy[1][2:0];
        for (int i = 0; i < 3; i++) begin
            ifb.req_dest[i] = s_dest[1][i];
            ifb.req_addr[i] = s_addr[1][i];
        end
    end

    // Reference model state: one bus transaction in flight per instance.
    int          np [2] = '{4, 3};
    int          tt [2] = '{10, 1};
    bit          m_busy [2];
    bit          m_dlv  [2];
    int          m_age  [2];
    int          m_src  [2];
    int          m_dest [2];
    logic [47:0] m_addr [2];
    int          m_rr   [2];
    int          e_grant[2];
    bit          e_err  [2];

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_busy[k] = 0; m_dlv[k] = 0; m_age[k] = 0; m_src[k] = 0;
            m_dest[k] = 0; m_addr[k] = '0; m_rr[k] = 0; e_grant[k] = 0; e_err[k] = 0;
        end
    endtask

    // Advance the model by one rising edge. It uses the inputs present at that edge.
    task automatic model_step(input int k);
        int  n;
        int  w;
        bit  hit;
        n          = np[k];
        e_grant[k] = 0;
        e_err[k]   = 0;
        if (m_dlv[k]) begin
            if (s_rdy[k][m_dest[k]]) begin
                m_dlv[k]  = 0;
                m_busy[k] = 0;
            end
        end else if (m_busy[k]) begin
            m_age[k]++;
            if (m_age[k] == tt[k]) begin
                if (m_dest[k] >= n) begin
                    e_err[k]  = 1;
                    m_busy[k] = 0;
                end else begin
                    m_dlv[k] = 1;
                end
            end
        end else begin
            hit = 0;
            w   = 0;
            for (int j = 0; j < n; j++) begin
                int c;
                c = (m_rr[k] + j) % n;
                if (!hit && s_req[k][c]) begin
                    hit = 1;
                    w   = c;
                end
            end
            if (hit) begin
                e_grant[k] = 1 << w;
                m_src[k]   = w;
                m_dest[k]  = int'(s_dest[k][w]);
                m_addr[k]  = s_addr[k][w];
                m_age[k]   = 0;
                m_busy[k]  = 1;
                m_rr[k]    = (w + 1) % n;
            end
        end
    endtask

    task automatic check_model();
        chk("a_grant",   ifa.grant,         e_grant[0]);
        chk("a_busy",    ifa.bus_busy,      m_busy[0]);
        chk("a_src",     ifa.xfer_src,      m_src[0]);
        chk("a_dest",    ifa.xfer_dest,     m_dest[0]);
        chk("a_dvalid",  ifa.deliver_valid, m_dlv[0] ? (1 << m_dest[0]) : 0);
        chk("a_daddr",   ifa.deliver_addr,  m_dlv[0] ? m_addr[0] : 48'h0);
        chk("a_err",     ifa.err_bad_dest,  e_err[0]);
        chk("b_grant",   ifb.grant,         e_grant[1]);
        chk("b_busy",    ifb.bus_busy,      m_busy[1]);
        chk("b_src",     ifb.xfer_src,      m_src[1]);
        chk("b_dest",    ifb.xfer_dest,     m_dest[1]);
        chk("b_dvalid",  ifb.deliver_valid, m_dlv[1] ? (1 << m_dest[1]) : 0);
        chk("b_daddr",   ifb.deliver_addr,  m_dlv[1] ? m_addr[1] : 48'h0);
        chk("b_err",     ifb.err_bad_dest,  e_err[1]);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_a_grant"},  ifa.grant,         0);
        chk({tag, "_a_busy"},   ifa.bus_busy,      0);
        chk({tag, "_a_src"},    ifa.xfer_src,      0);
        chk({tag, "_a_dest"},   ifa.xfer_dest,     0);
        chk({tag, "_a_dvalid"}, ifa.deliver_valid, 0);
        chk({tag, "_a_daddr"},  ifa.deliver_addr,  0);
        chk({tag, "_a_err"},    ifa.err_bad_dest,  0);
        chk({tag, "_b_busy"},   ifb.bus_busy,      0);
        chk({tag, "_b_dvalid"}, ifb.deliver_valid, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        model_step(0);
        model_step(1);
        check_model();
    endtask

    task automatic clear_stim();
        for (int k = 0; k < 2; k++) begin
            s_req[k] = '0;
            s_rdy[k] = '0;
            for (int i = 0; i < 4; i++) begin
                s_dest[k][i] = '0;
                s_addr[k][i] = '0;
            end
        end
    endtask

    task automatic do_reset();
        clear_stim();
        rst_l = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_zero("rst");
        @(negedge clk);
        rst_l = 1'b1;
    endtask

    // Random requests: a request is held until granted and sometimes dropped early.
    task automatic stim_random();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < np[k]; i++) begin
                if (e_grant[k][i]) begin
                    s_req[k][i] = 1'b0;
                end else if (s_req[k][i]) begin
                    if ($urandom_range(63) == 0) s_req[k][i] = 1'b0;
                end else if ($urandom_range(3) == 0) begin
                    s_req[k][i]  = 1'b1;
                    s_dest[k][i] = 2'($urandom_range(3));
                    s_addr[k][i] = 48'({$urandom(), $urandom()});
                end
            end
            s_rdy[k] = 4'($urandom()) | 4'($urandom());
        end
    endtask

    initial begin
        int last;
        int w;

        // Reset state, then round robin with every requester active.
        do_reset();
        s_req[0] = 4'b1111;
        s_rdy[0] = 4'hF;
        last = 0;
        for (int g = 0; g < 5; g++) begin
            w = 0;
            do begin
                tick();
                w++;
            end while (ifa.grant == 0 && w < 30);
            chk("rr_order", ifa.grant, 1 << (g % 4));
            if (g > 0) chk("rr_spacing", cyc - last, 12);
            last = cyc;
        end

        // Single request with fixed latencies.
        do_reset();
        s_req[0]     = 4'b0100;
        s_dest[0][2] = 2'd1;
        s_addr[0][2] = 48'h1234;
        s_rdy[0]     = 4'hF;
        tick();
        chk("single_grant", ifa.grant, 4'b0100);
        s_req[0] = 4'b0000;
        repeat (9) tick();
        chk("single_dvalid_early", ifa.deliver_valid, 4'b0000);
        tick();
        chk("single_dvalid", ifa.deliver_valid, 4'b0010);
        chk("single_daddr",  ifa.deliver_addr,  48'h1234);
        tick();
        chk("single_idle",   ifa.bus_busy,      1'b0);

        // Asynchronous reset while countdown is 5.
        s_req[0]     = 4'b0001;
        s_dest[0][0] = 2'd3;
        tick();
        chk("midrst_grant", ifa.grant, 4'b0001);
        s_req[0] = 4'b0000;
        repeat (4) tick();
        chk("midrst_busy", ifa.bus_busy, 1'b1);
        rst_l = 1'b0;
        #1;
        check_zero("midrst");
        do_reset();
        for (int i = 0; i < 15; i++) begin
            tick();
            chk("midrst_no_dvalid", ifa.deliver_valid, 4'b0000);
        end

        // Random traffic on both instances.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            stim_random();
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_PROC, default 4, meaning the number of requesters and destinations (at least 2).
REQ-002 The block SHALL have parameter TRANSFER_TIME, default 10, meaning the bus occupancy in cycles per transfer (at least 1).
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset, with ports as follows.
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 rst_l  input  1  asynchronous active-low reset.
REQ-006 req  input  NUM_PROC  per-requester request; held high until granted.
REQ-007 req_dest  input  NUM_PROC x $clog2(NUM_PROC)  per-requester destination index.
REQ-008 req_addr  input  NUM_PROC x 48  per-requester memory address.
REQ-009 dest_ready  input  NUM_PROC  per-destination ready to accept a delivery.
REQ-010 grant  output  NUM_PROC  one-hot, one-cycle acceptance pulse to the winning requester.
REQ-011 bus_busy  output  1  high whenever the FSM is not in IDLE.
REQ-012 xfer_src  output  $clog2(NUM_PROC)  latched source of the current transfer.
REQ-013 xfer_dest  output  $clog2(NUM_PROC)  latched destination of the current transfer.
REQ-014 deliver_valid  output  NUM_PROC  one-hot delivery strobe to the destination.
REQ-015 deliver_addr  output  48  latched address; 0 when no deliver_valid bit is high.
REQ-016 err_bad_dest  output  1  one-cycle pulse when a granted request names a destination at or above NUM_PROC.

Function
REQ-017 The FSM SHALL have exactly the states IDLE, XFER and DELIVER.
REQ-018 In IDLE with req nonzero, the block SHALL select a winner at the clock edge:
- the winner is the first set bit scanning up from rr_ptr, wrapping from NUM_PROC-1 to 0;
- on that edge it registers grant[winner]=1 for exactly one cycle;
- it latches src/dest/addr;
- it loads the countdown with TRANSFER_TIME-1 and enters XFER.
REQ-019 On each grant, rr_ptr SHALL update to winner+1, wrapping NUM_PROC-1 to 0; rr_ptr SHALL hold otherwise.
REQ-020 In IDLE with req zero, the state SHALL remain IDLE and grant SHALL be 0.
REQ-021 req SHALL be sampled only in IDLE; req changes during XFER and DELIVER SHALL be ignored.
REQ-022 A requester that drops req before its grant SHALL receive no grant.
REQ-023 In XFER, the countdown SHALL decrement by 1 per cycle; at countdown 0 the next state SHALL be DELIVER, so XFER lasts exactly TRANSFER_TIME cycles.
REQ-024 The countdown SHALL be $clog2(TRANSFER_TIME+1) bits wide and SHALL never underflow.
REQ-025 In DELIVER, deliver_valid[xfer_dest] SHALL be 1 and deliver_addr SHALL equal the latched address.
REQ-026 DELIVER SHALL hold until dest_ready[xfer_dest]=1; on that edge the state SHALL return to IDLE and deliver_valid SHALL clear.
REQ-027 Re-arbitration SHALL occur no earlier than the first cycle back in IDLE.
REQ-028 If the latched dest is at or above NUM_PROC, the block SHALL skip DELIVER: at the end of XFER it pulses err_bad_dest for one cycle and returns to IDLE.
REQ-029 Request-to-grant latency SHALL be 1 cycle.
REQ-030 Grant-to-deliver_valid latency SHALL be TRANSFER_TIME cycles.
REQ-031 Minimum spacing between consecutive grants SHALL be TRANSFER_TIME+2 cycles.
REQ-032 grant SHALL be one-hot or zero, and SHALL never assert outside the IDLE-to-XFER transition.
REQ-033 deliver_valid SHALL be one-hot or zero.

Reset
REQ-034 While rst_l=0, asynchronously: state=IDLE, rr_ptr=0, countdown=0, and every output is 0 (grant, bus_busy, xfer_src, xfer_dest, deliver_valid, deliver_addr, err_bad_dest).
REQ-035 Reset asserted mid-XFER or mid-DELIVER SHALL abandon the transfer; no grant, delivery or error pulse SHALL follow reset release without a new request.
REQ-036 The first arbitration after reset SHALL favour requester 0.

Verification
REQ-037 Single request, NUM_PROC=4, TRANSFER_TIME=10: req=0b0100, req_dest[2]=1, req_addr[2]=0x1234, dest_ready=all 1 -> grant=0b0100 at t+1; deliver_valid=0b0010 with deliver_addr=0x1234 at t+11; IDLE at t+12.
REQ-038 Round robin: req=0b1111 held throughout -> grants in order 0,1,2,3,0, spaced 12 cycles apart.
REQ-039 Backpressure: dest_ready[1]=0 for 5 cycles during DELIVER -> deliver_valid=0b0010 held for 6 cycles; bus_busy stays 1; no grant during that time.
REQ-040 Wrap priority: rr_ptr=3, req=0b0011 -> grant to requester 0; rr_ptr becomes 1.
REQ-041 Reset mid-XFER: rst_l low at countdown 5 -> all outputs 0 immediately; no deliver_valid after release with req=0.
REQ-042 TRANSFER_TIME=1: back-to-back requests -> deliver_valid one cycle after grant; grants spaced 3 cycles apart.
